rc_pwm_receiver: RTL and testbench
==================================

// Module: rc_pwm_receiver
// PURPOSE
//  Decodes the 7 PWM servo channels of the hobby RC receiver (throttle/yaw/roll/pitch/mode/aux1/aux2)
//  into registered scaled values for the flight-control logic. Each channel's high-pulse width is
//  measured in microseconds and mapped to an unsigned value. Sits between receiver pins and controller.
// PARAMETERS
//  N_VAL      14       width of throttle/yaw/roll/pitch_val
//  N_AUX      4        width of aux1_val/aux2_val
//  N_MODE     3        width of mode_val
//  TICKS_US   12       sys_clk cycles per microsecond (12 MHz default), >=2
//  TIMEOUT_US 25000    failsafe timeout (used only with RX_TIMEOUT_EN)
// PORTS
//  sys_clk       in   1       system clock, all logic rising-edge
//  resetn        in   1       synchronous active-low reset
//  throttle_pwm  in   1       async PWM input; also yaw_pwm, roll_pwm, pitch_pwm, mode_pwm, aux1_pwm, aux2_pwm
//  throttle_val  out  N_VAL   scaled throttle; also yaw_val, roll_val, pitch_val (N_VAL each)
//  mode_val      out  N_MODE  scaled mode switch
//  aux1_val      out  N_AUX   scaled aux1; aux2_val same
// BEHAVIOUR
//  - Reset (resetn=0 at sys_clk edge): all outputs 0, all counters/synchronizers cleared; a pulse in
//    flight when reset releases is discarded (measurement starts only at next synchronized rising edge).
//  - Each *_pwm passes a 2-flop synchronizer, then an edge detector on the synchronized copy.
//  - Shared prescaler: us_tick asserted 1 cycle every TICKS_US cycles, free-running from reset.
//  - Per channel width counter W (12 bits): cleared on rising edge, +1 per us_tick while high,
//    saturates at 4095. Quantization error +/-1 us.
//  - On falling edge: pulse valid iff 800 <= W <= 2500; valid -> output register updated next cycle
//    (<=4 sys_clk from pin falling edge to output); invalid -> output holds previous value.
//  - Scaling, D = W-1000 saturated to 0..1000 (W<1000 -> 0, W>2000 -> 1000):
//      throttle/yaw/roll/pitch_val = D (zero-extended to N_VAL)
//      aux*_val  = min(D>>6, 2^N_AUX-1)   (1000>>6=15)
//      mode_val  = min(D>>7, 2^N_MODE-1)  (1000>>7=7)
//  - Channels independent; simultaneous edges on all channels handled in same cycle.
//  - Outputs glitch-free: change only at the single update cycle after a valid falling edge.
//  - Pin held constant (no edges): outputs hold (unless RX_TIMEOUT_EN).
// CONFIGURATION
//  RX_TIMEOUT_EN defined: per-channel counter counts us_ticks since last valid pulse end; reaching
//    TIMEOUT_US forces that channel's output to 0 (failsafe, throttle off) until next valid pulse;
//    counter cleared by reset and by every valid pulse.
//  RX_TIMEOUT_EN undefined: no timeout logic; outputs hold last valid value indefinitely.
// TESTING
//  1 Reset: resetn=0 two cycles, pins toggling -> every output 0 throughout reset and after release.
//  2 throttle_pwm 1500 us high / 20 ms period -> throttle_val=500 (+/-1) within 4 clk of falling edge.
//  3 roll 1000 us -> 0; pitch 2000 us -> 1000; yaw 2200 us -> 1000 (saturate); 3000 us -> value held.
//  4 aux1 1500 us -> aux1_val=7; aux2 2000 us -> 15; mode 2000 us -> 7; mode 1300 us -> 2.
//  5 Reset asserted mid 1500 us pulse -> outputs 0, that pulse ignored, next 1500 us pulse -> 500.
//  6 RX_TIMEOUT_EN: valid 1500 us then pin low 30 ms -> throttle_val 0 at 25 ms; undefined -> stays 500.

Source files
------------

// File: rtl/rc_pwm_receiver.sv
// Seven-channel RC servo PWM decoder: measures each high pulse in microseconds and registers a scaled value.
// Define RX_TIMEOUT_EN to add a per-channel failsafe that zeroes a channel after TIMEOUT_US without a valid pulse.
module rc_pwm_receiver #(
    parameter int N_VAL      = 14,
    parameter int N_AUX      = 4,
    parameter int N_MODE     = 3,
    parameter int TICKS_US   = 12,
    parameter int TIMEOUT_US = 25000
) (
    input  logic              sys_clk,
    input  logic              resetn,
    input  logic              throttle_pwm,
    input  logic              yaw_pwm,
    input  logic              roll_pwm,
    input  logic              pitch_pwm,
    input  logic              mode_pwm,
    input  logic              aux1_pwm,
    input  logic              aux2_pwm,
    output logic [N_VAL-1:0]  throttle_val,
    output logic [N_VAL-1:0]  yaw_val,
    output logic [N_VAL-1:0]  roll_val,
    output logic [N_VAL-1:0]  pitch_val,
    output logic [N_MODE-1:0] mode_val,
    output logic [N_AUX-1:0]  aux1_val,
    output logic [N_AUX-1:0]  aux2_val
);

    localparam int          NCH   = 7;
    localparam int          PS_W  = $clog2(TICKS_US);
    localparam logic [11:0] W_MIN = 12'd800;
    localparam logic [11:0] W_MAX = 12'd2500;
    localparam logic [11:0] W_SAT = 12'hFFF;

    typedef enum logic [1:0] {
        CH_WAIT_LOW,
        CH_ARMED,
        CH_MEASURE
    } ch_state_t;

    logic [NCH-1:0]   pwm_raw;
    logic [NCH-1:0]   sync1;
    logic [NCH-1:0]   sync2;
    logic [NCH-1:0]   sync_prev;
    logic [NCH-1:0]   rise;
    logic [NCH-1:0]   fall;
    logic [NCH-1:0]   start;
    logic [NCH-1:0]   done;
    logic [NCH-1:0]   valid;
    logic [1:0]       sync_fill;
    logic             sync_ready;
    logic [PS_W-1:0]  ps_cnt;
    logic             us_tick;
    ch_state_t        state [NCH];
    ch_state_t        state_next [NCH];
    logic [11:0]      pulse_w [NCH];
    logic [9:0]       scaled [NCH];
    logic [N_VAL-1:0] val_q [4];
    logic [N_MODE-1:0] mode_q;
    logic [N_AUX-1:0] aux_q [2];

    function automatic logic [9:0] scale_d(input logic [11:0] w);
        if (w <= 12'd1000)
            return 10'd0;
        else if (w >= 12'd2000)
            return 10'd1000;
        else
            return 10'(w - 12'd1000);
    endfunction

    function automatic int clip_shift(input logic [9:0] d, input int sh, input int bits);
        int q;
        int lim;
        q   = int'(d >> sh);
        lim = (1 << bits) - 1;
        return (q > lim) ? lim : q;
    endfunction

    assign pwm_raw = {aux2_pwm, aux1_pwm, mode_pwm, pitch_pwm, roll_pwm, yaw_pwm, throttle_pwm};

    // sync_fill marks when sync2 holds real pin samples rather than reset zeros
    always_ff @(posedge sys_clk) begin
        if (!resetn) begin
            sync1     <= '0;
            sync2     <= '0;
            sync_prev <= '0;
            sync_fill <= '0;
        end else begin
            sync1     <= pwm_raw;
            sync2     <= sync1;
            sync_prev <= sync2;
            sync_fill <= {sync_fill[0], 1'b1};
        end
    end

    assign sync_ready = sync_fill[1];
    assign rise       = sync2 & ~sync_prev;
    assign fall       = ~sync2 & sync_prev;

    always_ff @(posedge sys_clk) begin
        if (!resetn)
            ps_cnt <= '0;
        else if (us_tick)
            ps_cnt <= '0;
        else
            ps_cnt <= ps_cnt + 1'b1;
    end

    assign us_tick = (ps_cnt == PS_W'(TICKS_US - 1));

    always_ff @(posedge sys_clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (!resetn)
                state[i] <= CH_WAIT_LOW;
            else
                state[i] <= state_next[i];
        end
    end

    // A channel must see its pin low before a rise counts, so a pulse already high at reset release is dropped
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            state_next[i] = state[i];
            start[i]      = 1'b0;
            done[i]       = 1'b0;
            case (state[i])
                CH_WAIT_LOW: begin
                    if (sync_ready && !sync2[i])
                        state_next[i] = CH_ARMED;
                end
                CH_ARMED: begin
                    if (rise[i]) begin
                        start[i]      = 1'b1;
                        state_next[i] = CH_MEASURE;
                    end
                end
                CH_MEASURE: begin
                    if (fall[i]) begin
                        done[i]       = 1'b1;
                        state_next[i] = CH_ARMED;
                    end
                end
                default: state_next[i] = CH_WAIT_LOW;
            endcase
        end
    end

    // The rise cycle already counts a coincident tick so k*TICKS_US high cycles give exactly k
    always_ff @(posedge sys_clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (!resetn)
                pulse_w[i] <= '0;
            else if (start[i])
                pulse_w[i] <= {11'd0, us_tick};
            else if (state[i] == CH_MEASURE && sync2[i] && us_tick && pulse_w[i] != W_SAT)
                pulse_w[i] <= pulse_w[i] + 12'd1;
        end
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            scaled[i] = scale_d(pulse_w[i]);
            valid[i]  = done[i] && (pulse_w[i] >= W_MIN) && (pulse_w[i] <= W_MAX);
        end
    end

`ifdef RX_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_US + 1);

    logic [TO_W-1:0] to_cnt [NCH];
    logic [NCH-1:0]  expire;

    always_ff @(posedge sys_clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (!resetn)
                to_cnt[i] <= '0;
            else if (valid[i])
                to_cnt[i] <= '0;
            else if (us_tick && to_cnt[i] != TO_W'(TIMEOUT_US))
                to_cnt[i] <= to_cnt[i] + 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < NCH; i++)
            expire[i] = us_tick && (to_cnt[i] == TO_W'(TIMEOUT_US - 1));
    end
`endif

    always_ff @(posedge sys_clk) begin
        if (!resetn) begin
            for (int i = 0; i < 4; i++)
                val_q[i] <= '0;
            mode_q <= '0;
            for (int i = 0; i < 2; i++)
                aux_q[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (valid[i])
                    val_q[i] <= N_VAL'(scaled[i]);
`ifdef RX_TIMEOUT_EN
                else if (expire[i])
                    val_q[i] <= '0;
`endif
            end
            if (valid[4])
                mode_q <= N_MODE'(clip_shift(scaled[4], 7, N_MODE));
`ifdef RX_TIMEOUT_EN
            else if (expire[4])
                mode_q <= '0;
`endif
            for (int i = 0; i < 2; i++) begin
                if (valid[5+i])
                    aux_q[i] <= N_AUX'(clip_shift(scaled[5+i], 6, N_AUX));
`ifdef RX_TIMEOUT_EN
                else if (expire[5+i])
                    aux_q[i] <= '0;
`endif
            end
        end
    end

    assign throttle_val = val_q[0];
    assign yaw_val      = val_q[1];
    assign roll_val     = val_q[2];
    assign pitch_val    = val_q[3];
    assign mode_val     = mode_q;
    assign aux1_val     = aux_q[0];
    assign aux2_val     = aux_q[1];

endmodule

// File: tb/tb_rc_pwm_receiver.sv
// Bench for rc_pwm_receiver: directed and random pulse widths checked against a microsecond-level model.
// Runs with TICKS_US=2 and TIMEOUT_US=3000 so every scenario fits in a short simulation.
module tb_rc_pwm_receiver;

    localparam int T      = 2;
    localparam int TO_US  = 3000;
    localparam int MARGIN = 4 * T + 8;
`ifdef RX_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        sys_clk = 1'b0;
    logic        resetn  = 1'b0;
    logic [6:0]  pins    = '0;
    logic [13:0] throttle_val;
    logic [13:0] yaw_val;
    logic [13:0] roll_val;
    logic [13:0] pitch_val;
    logic [2:0]  mode_val;
    logic [3:0]  aux1_val;
    logic [3:0]  aux2_val;

    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;
    int    exp_d [7];
    int    last_valid [7];
    int    stim_w [7];
    string names [7] = '{"throttle", "yaw", "roll", "pitch", "mode", "aux1", "aux2"};

    rc_pwm_receiver #(
        .N_VAL(14), .N_AUX(4), .N_MODE(3), .TICKS_US(T), .TIMEOUT_US(TO_US)
    ) dut (
        .sys_clk(sys_clk),
        .resetn(resetn),
        .throttle_pwm(pins[0]),
        .yaw_pwm(pins[1]),
        .roll_pwm(pins[2]),
        .pitch_pwm(pins[3]),
        .mode_pwm(pins[4]),
        .aux1_pwm(pins[5]),
        .aux2_pwm(pins[6]),
        .throttle_val(throttle_val),
        .yaw_val(yaw_val),
        .roll_val(roll_val),
        .pitch_val(pitch_val),
        .mode_val(mode_val),
        .aux1_val(aux1_val),
        .aux2_val(aux2_val)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    function automatic bit ref_valid(input int w);
        return (w >= 800) && (w <= 2500);
    endfunction

    function automatic int ref_d(input int w);
        if (w < 1000) return 0;
        if (w > 2000) return 1000;
        return w - 1000;
    endfunction

    function automatic int clip(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    task automatic check_one(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
            $error("[TB] %s observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Channels sitting right at the failsafe boundary are skipped since the exact firing cycle is not pinned down
    task automatic check_output(input string tag);
        logic [31:0] obs [7];
        int d;
        int el;
        int e;
        obs[0] = 32'(throttle_val);
        obs[1] = 32'(yaw_val);
        obs[2] = 32'(roll_val);
        obs[3] = 32'(pitch_val);
        obs[4] = 32'(mode_val);
        obs[5] = 32'(aux1_val);
        obs[6] = 32'(aux2_val);
        for (int i = 0; i < 7; i++) begin
            el = cyc - last_valid[i];
            d  = exp_d[i];
            if (TO_EN && el >= TO_US * T + MARGIN) d = 0;
            if (!(TO_EN && el > TO_US * T - MARGIN && el < TO_US * T + MARGIN)) begin
                if (i < 4)       e = d;
                else if (i == 4) e = clip(d / 128, 7);
                else             e = clip(d / 64, 15);
                check_one($sformatf("%s_%s", tag, names[i]), obs[i], 32'(e));
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 7; i++) begin
            exp_d[i]      = 0;
            last_valid[i] = cyc;
        end
    endtask

    // Every channel with a nonzero width starts high on the same edge; outputs are checked 4 clocks after the last fall
    task automatic apply_stimulus(input string tag);
        int max_c;
        max_c = 0;
        for (int i = 0; i < 7; i++)
            if (stim_w[i] * T > max_c) max_c = stim_w[i] * T;
        for (int c = 0; c < max_c; c++) begin
            @(negedge sys_clk);
            for (int i = 0; i < 7; i++) pins[i] = (c < stim_w[i] * T);
        end
        @(negedge sys_clk);
        pins = '0;
        for (int i = 0; i < 7; i++) begin
            if (stim_w[i] > 0 && ref_valid(stim_w[i])) begin
                exp_d[i]      = ref_d(stim_w[i]);
                last_valid[i] = cyc - (max_c - stim_w[i] * T);
            end
        end
        repeat (4) @(posedge sys_clk);
        #1;
        check_output(tag);
        repeat (20) @(negedge sys_clk);
    endtask

    initial begin
        model_reset();

        resetn = 1'b0;
        repeat (2) begin
            @(negedge sys_clk);
            pins = 7'($urandom);
        end
        check_output("in_reset");
        @(negedge sys_clk);
        resetn = 1'b1;
        model_reset();
        repeat (12) begin
            @(negedge sys_clk);
            pins = 7'($urandom);
        end
        @(negedge sys_clk);
        pins = '0;
        repeat (6) @(negedge sys_clk);
        check_output("after_release");

        stim_w = '{1500, 0, 0, 0, 0, 0, 0};
        apply_stimulus("thr1500");
        stim_w = '{0, 0, 1700, 0, 0, 0, 0};
        apply_stimulus("roll1700");
        stim_w = '{0, 2200, 1000, 2000, 0, 0, 0};
        apply_stimulus("rpy_mix");
        stim_w = '{0, 3000, 0, 0, 0, 0, 0};
        apply_stimulus("yaw3000_held");
        stim_w = '{0, 0, 0, 0, 2000, 1500, 2000};
        apply_stimulus("aux_mode");
        stim_w = '{0, 0, 0, 0, 1300, 0, 0};
        apply_stimulus("mode1300");

        @(negedge sys_clk);
        pins[0] = 1'b1;
        repeat (300 * T) @(negedge sys_clk);
        resetn = 1'b0;
        repeat (2) @(negedge sys_clk);
        resetn = 1'b1;
        model_reset();
        repeat (1200 * T - 2) @(negedge sys_clk);
        pins[0] = 1'b0;
        repeat (6) @(negedge sys_clk);
        check_output("reset_mid_pulse");
        repeat (20) @(negedge sys_clk);
        stim_w = '{1500, 0, 0, 0, 0, 0, 0};
        apply_stimulus("after_mid_reset");

        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 7; i++)
                stim_w[i] = ($urandom_range(3, 0) == 0) ? 0 : int'($urandom_range(2600, 700));
            apply_stimulus($sformatf("rand%0d", k));
        end

        stim_w = '{1500, 0, 0, 0, 0, 0, 0};
        apply_stimulus("timeout_arm");
        repeat ((TO_US - 200) * T) @(negedge sys_clk);
        check_output("pre_timeout");
        repeat (400 * T) @(negedge sys_clk);
        check_output("post_timeout");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
